seq_detector_prog: RTL and testbench

SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/sat_counter.sv | 44 ++++
 rtl/seq_detector_prog.sv | 102 ++++++++++
 tb/tb_seq_detector_prog.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants, mode encoding and length clamping for the programmable
// serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        MODE_NONOVERLAP = 1'b0,
        MODE_OVERLAP    = 1'b1
    } mode_e;

    localparam int         DEF_MAX_LEN_C = 8;
    localparam int         DEF_CNT_W_C   = 8;
    localparam logic [7:0] DEF_PATTERN_C = 8'b0000_1011;
    localparam int         DEF_LEN_C     = 4;
    localparam bit         DEF_OVERLAP_C = 1'b1;

    // A zero or oversized length means "use the whole history window".
    function automatic int clamp_len(input int len, input int max_len);
        return (len <= 0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky flag raised when
// an increment arrives while the count is already all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             sat_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc_i) begin
            if (&count_q) sat_d = 1'b1;
            else          count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: shifts qualified bits into a history
// window and pulses detected when the low len bits equal the loaded pattern.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN_C,
    parameter int                 CNT_W       = DEF_CNT_W_C,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int                 DEF_LEN     = DEF_LEN_C,
    parameter bit                 DEF_OVERLAP = DEF_OVERLAP_C,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0] MAX_LEN_W   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] RST_LEN     = LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
    localparam mode_e            RST_MODE    = DEF_OVERLAP ? MODE_OVERLAP : MODE_NONOVERLAP;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
    logic [LEN_W-1:0]   len_q, len_d, cfg_len_clamped;
    mode_e              mode_q, mode_d;
    logic               det_q, det_d;
    logic               match;
    logic [MAX_LEN-1:0] len_mask;

    assign cfg_len_clamped = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (LEN_W'(i) < len_q);
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        hist_d   = hist_q;
        pat_d    = pat_q;
        len_d    = len_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        fill_inc = fill_q;
        det_d    = 1'b0;
        match    = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len_clamped;
            mode_d = mode_e'(cfg_overlap);
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = {hist_q[MAX_LEN-2:0], in_bit};
            if (fill_q != MAX_LEN_W) fill_inc = fill_q + LEN_W'(1);
            match  = (fill_inc >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0);
            det_d  = match;
            fill_d = (match && mode_q == MODE_NONOVERLAP) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PATTERN;
            len_q  <= RST_LEN;
            mode_q <= RST_MODE;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            mode_q <= mode_d;
            det_q  <= det_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cfg_load),
        .inc_i   (match),
        .count_o (match_count),
        .sat_o   (count_sat)
    );

    assign detected = det_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: directed scenarios followed by random traffic,
// compared cycle by cycle against a bit-queue reference model.
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_bit, cfg_load, cfg_overlap;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;

    logic       det_a, sat_a, det_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         mq[$];
    int         m_fill, m_len, m_cnt_a, m_cnt_b;
    bit         m_ovl, m_det, m_sat_a, m_sat_b;
    logic [7:0] m_pat;

    always #5 clk = ~clk;

    seq_detector_prog dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .detected(det_a), .match_count(cnt_a),
        .count_sat(sat_a)
    );

    seq_detector_prog #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .detected(det_b), .match_count(cnt_b),
        .count_sat(sat_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_det_a"}, 32'(det_a), 32'(m_det));
        check({tag, "_cnt_a"}, 32'(cnt_a), 32'(m_cnt_a));
        check({tag, "_sat_a"}, 32'(sat_a), 32'(m_sat_a));
        check({tag, "_det_b"}, 32'(det_b), 32'(m_det));
        check({tag, "_cnt_b"}, 32'(cnt_b), 32'(m_cnt_b));
        check({tag, "_sat_b"}, 32'(sat_b), 32'(m_sat_b));
    endtask

    task automatic model_reset();
        mq.delete();
        m_fill  = 0;
        m_pat   = 8'b0000_1011;
        m_len   = 4;
        m_ovl   = 1'b1;
        m_det   = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_sat_a = 1'b0;
        m_sat_b = 1'b0;
    endtask

    // Applies the rules to the inputs present at the rising edge just taken.
    task automatic model_edge();
        bit hit;
        if (cfg_load) begin
            m_pat   = cfg_pattern;
            m_len   = (cfg_len == 0 || cfg_len > 8) ? 8 : int'(cfg_len);
            m_ovl   = cfg_overlap;
            m_fill  = 0;
            mq.delete();
            m_det   = 1'b0;
            m_cnt_a = 0;
            m_cnt_b = 0;
            m_sat_a = 1'b0;
            m_sat_b = 1'b0;
        end else if (in_valid) begin
            mq.push_back(in_bit);
            if (mq.size() > 64) void'(mq.pop_front());
            if (m_fill < 8) m_fill++;
            hit = (m_fill >= m_len);
            if (hit)
                for (int k = 0; k < m_len; k++)
                    if (mq[mq.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            m_det = hit;
            if (hit) begin
                if (m_cnt_a == 255) m_sat_a = 1'b1; else m_cnt_a++;
                if (m_cnt_b == 3)   m_sat_b = 1'b1; else m_cnt_b++;
                if (!m_ovl) m_fill = 0;
            end
        end else begin
            m_det = 1'b0;
        end
    endtask

    task automatic cyc(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        cfg_load = 1'b0;
        @(posedge clk);
        model_edge();
        #1 check_all("cyc");
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_valid    = 1'b1;
        in_bit      = 1'b1;
        @(posedge clk);
        model_edge();
        #1 check_all("load");
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        cfg_load = 1'b0;
        rst      = 1'b1;
        model_reset();
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        model_reset();
        #1 check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Default pattern 1011, single hit
        cyc(1, 1); cyc(1, 0); cyc(1, 1); cyc(1, 1);
        check("d1011_pulse", 32'(det_a), 32'd1);
        check("d1011_count", 32'(cnt_a), 32'd1);
        cyc(0, 0);
        check("d1011_one_cycle", 32'(det_a), 32'd0);

        // Overlapping vs non-overlapping on 1011011
        do_reset();
        cyc(1, 1); cyc(1, 0); cyc(1, 1); cyc(1, 1); cyc(1, 0); cyc(1, 1); cyc(1, 1);
        check("ovl_count", 32'(cnt_a), 32'd2);
        load(8'b0000_1011, 4'd4, 1'b0);
        cyc(1, 1); cyc(1, 0); cyc(1, 1); cyc(1, 1); cyc(1, 0); cyc(1, 1); cyc(1, 1);
        check("novl_count", 32'(cnt_a), 32'd1);

        // Gap cycle inside the pattern
        do_reset();
        cyc(1, 1); cyc(0, 0);
        check("gap_no_pulse", 32'(det_a), 32'd0);
        cyc(1, 0); cyc(1, 1); cyc(1, 1);
        check("gap_pulse", 32'(det_a), 32'd1);

        // 111 overlap, then cfg_len=0 clamps to the full window
        load(8'b0000_0111, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1, 1);
        check("p111_count", 32'(cnt_a), 32'd3);
        load(8'b0000_0111, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1, 1);
        check("clamp_count", 32'(cnt_a), 32'd0);

        // Saturation on the 2-bit counter, then cleared by a load
        load(8'b0000_0001, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1, 1);
        check("sat_cnt_b", 32'(cnt_b), 32'd3);
        check("sat_flag_b", 32'(sat_b), 32'd1);
        load(8'b0000_0001, 4'd1, 1'b1);
        check("sat_clear_b", 32'({sat_b, cnt_b}), 32'd0);

        // Reset pulsed mid-cycle discards the partial 101
        do_reset();
        cyc(1, 1); cyc(1, 0); cyc(1, 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        #1 rst = 1'b0;
        cyc(0, 0);
        cyc(1, 1);
        check("post_rst_no_pulse", 32'(det_a), 32'd0);
        cyc(1, 0); cyc(1, 1); cyc(1, 1);
        check("post_rst_default", 32'(det_a), 32'd1);

        // Random traffic with occasional loads and resets
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) do_reset();
            else if (r < 5)
                load(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
            else if (r < 9)
                load(8'($urandom), 4'($urandom_range(1, 3)), 1'($urandom));
            else
                cyc($urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
